mem_arr_rd_seq: RTL and testbench
=================================

Name: mem_arr_rd_seq

Overview:
- Read-side scheduler for the per-row SRAM bank array that feeds the systolic array (SYS_ROW banks, 256 entries each).
- On a start command it issues a diagonally skewed read sweep: row i begins reading i cycles after row 0.
- Data therefore reaches the array in wavefront order.
- Produces per-row read enables and addresses, a per-row data-valid aligned to the 1-cycle BRAM read latency, and busy/done status.

Parameters:
- SYS_ROW, 16, number of rows/banks.
- ADDR_WIDTH, 8, bank address width; the bank holds 2^ADDR_WIDTH entries.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  command strobe; sampled only in IDLE
- base_addr  input  ADDR_WIDTH  first address read by every row
- len  input  ADDR_WIDTH+1  entries per row; 0 = no-op; values above 2^ADDR_WIDTH saturate to 2^ADDR_WIDTH
- stall  input  1  freeze sweep (downstream back-pressure)
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse at the end of a sweep
- rd_en  output  SYS_ROW  per-row read enable (bit i = row i)
- rd_addr  output  SYS_ROW*ADDR_WIDTH  row i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- data_valid  output  SYS_ROW  rd_en delayed one cycle; marks a valid bank read-data word

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, rd_en, data_valid = 0; rd_addr = 0. All outputs are registered.
- On rst deassertion: resumes in IDLE; no output glitch.
- Reset mid-sweep aborts immediately; no done pulse.
- States:
  - IDLE: busy=0.
    - start=1 and len!=0: latch base_addr and saturated len (L), clear sweep counter t=0, go to RUN.
    - start with len=0: ignored; no busy, no done.
  - RUN: busy=1. Sweep counter t spans 0..L+SYS_ROW-2.
    - Each non-stalled cycle, row i outputs rd_en[i]=1 iff i <= t < i+L, with rd_addr_i = (base + t - i) mod 2^ADDR_WIDTH (wraps past 2^ADDR_WIDTH-1 to 0).
    - After issuing t=L+SYS_ROW-2, go to FLUSH.
  - FLUSH: one cycle; busy=1, done=1, rd_en=0; data_valid[SYS_ROW-1] carries the final word. Then go to IDLE.
- Timing: start sampled at edge k -> first rd_en[0] visible after edge k+1.
- Stall-free sweep: exactly L+SYS_ROW-1 issue cycles; done appears L+SYS_ROW cycles after the start edge.
- Stall:
  - stall=1 during RUN: rd_en=0 for all rows and t holds.
  - rd_addr holds its last value; its value is don't-care while rd_en=0.
  - Resumes at the same t when stall drops.
  - stall in IDLE/FLUSH has no effect; FLUSH always completes.
- data_valid[i] equals rd_en[i] registered one cycle, including during stalls.
- start while busy: ignored; no queueing.
- Counter widths: t is wide enough for 2^ADDR_WIDTH+SYS_ROW-2. Address subtraction is modulo 2^ADDR_WIDTH.
- Total reads per sweep: SYS_ROW*L. Each row reads exactly L consecutive addresses.

Test Plan:
1. SYS_ROW=4, base=0x10, len=3, no stall -> 6 issue cycles.
   - Row0 reads 0x10,0x11,0x12 on issue cycles 0-2; row3 reads 0x10-0x12 on cycles 3-5.
   - done pulses on the cycle after issue cycle 5; busy high for 7 cycles.
2. base=0xFE, len=4, SYS_ROW=16 -> every row reads 0xFE,0xFF,0x00,0x01.
   - Total rd_en count 64; last rd_en on row 15 at issue cycle 18.
3. len=0 start -> busy, rd_en, done stay 0.
   - len=300 -> treated as 256; row0 reads 0x00-0xFF (base=0); sweep length 271 issue cycles.
4. Stall for 5 cycles mid-sweep (t=2, SYS_ROW=4, len=3) -> rd_en all 0 during stall; data_valid 0 one cycle later.
   - Sequence resumes at t=2 with identical addresses; done delayed exactly 5 cycles.
5. start pulsed while busy -> ignored.
   - rst asserted at t=1 -> outputs 0 immediately (asynchronous), no done.
   - A new start after reset runs a clean full sweep.
6. Back-to-back starts (start held high through FLUSH) -> second sweep's first rd_en one cycle after returning to IDLE samples start; no overlap with the first sweep's data_valid.

Source files
------------

// File: rtl/mem_arr_rd_seq.sv
// mem_arr_rd_seq: diagonally skewed read sweep over a per-row SRAM bank array (wavefront order)
//   clk, rst          : clock, asynchronous active-high reset
//   start             : sweep command, sampled only while idle
//   base_addr, len    : first address and entries per row (0 = no-op, saturates to 2^ADDR_WIDTH)
//   stall             : freezes the sweep while running
//   busy, done        : sweep in progress / one-cycle end-of-sweep pulse
//   rd_en, rd_addr    : per-row read enable and address (row i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//   data_valid        : rd_en delayed by the one-cycle bank read latency
module mem_arr_rd_seq #(
    parameter int SYS_ROW    = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           len,
    input  logic                          stall,
    output logic                          busy,
    output logic                          done,
    output logic [SYS_ROW-1:0]            rd_en,
    output logic [SYS_ROW*ADDR_WIDTH-1:0] rd_addr,
    output logic [SYS_ROW-1:0]            data_valid
);
    // sweep counter must reach 2^ADDR_WIDTH+SYS_ROW-1 after the final increment
    localparam int TW = $clog2((2 ** ADDR_WIDTH) + SYS_ROW);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                          r_state;
    logic [ADDR_WIDTH-1:0]           r_base;
    logic [ADDR_WIDTH:0]             r_len;
    logic [TW-1:0]                   r_t;
    logic [SYS_ROW-1:0]              w_en;
    logic [SYS_ROW*ADDR_WIDTH-1:0]   w_addr;
    logic                            w_last;

    assign w_last = r_t == TW'(r_len) + TW'(SYS_ROW - 2);

    // row i is active for i <= t < i+L and reads base+t-i (mod bank depth)
    for (genvar i = 0; i < SYS_ROW; i++) begin : g_row
        assign w_en[i] = (r_t >= TW'(i)) && ({1'b0, r_t} < (TW+1)'(i) + (TW+1)'(r_len));
        assign w_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_base + r_t[ADDR_WIDTH-1:0] - ADDR_WIDTH'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_t        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= '0;
            rd_addr    <= '0;
            data_valid <= '0;
        end else begin
            data_valid <= rd_en;
            done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    busy  <= 1'b0;
                    rd_en <= '0;
                    if (start && len != '0) begin
                        r_base  <= base_addr;
                        r_len   <= len > MAX_LEN ? MAX_LEN : len;
                        r_t     <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    busy  <= 1'b1;
                    rd_en <= stall ? '0 : w_en;
                    if (!stall) begin
                        rd_addr <= w_addr;
                        r_t     <= r_t + TW'(1);
                        r_state <= w_last ? FLUSH : RUN;
                    end
                end
                FLUSH: begin
                    busy    <= 1'b1;
                    done    <= 1'b1;
                    rd_en   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arr_rd_seq.sv
// tb_mem_arr_rd_seq: scoreboard bench for the skewed bank read sequencer
module tb_mem_arr_rd_seq;
    localparam int SR = 16;
    localparam int AW = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stall = 1'b0;
    logic [AW-1:0]      base_addr = '0;
    logic [AW:0]        len = '0;
    logic               busy;
    logic               done;
    logic [SR-1:0]      rd_en;
    logic [SR*AW-1:0]   rd_addr;
    logic [SR-1:0]      data_valid;

    typedef struct packed {
        logic                   busy;
        logic                   done;
        logic [SR-1:0]          en;
        logic [SR-1:0]          dv;
        logic [SR-1:0][AW-1:0]  addr;
    } exp_t;

    typedef struct packed {
        logic          start;
        logic          stall;
        logic [AW-1:0] base;
        logic [AW:0]   len;
    } drv_t;

    exp_t           exp_q[$];
    drv_t           drv_q[$];
    logic [SR-1:0]  last_en = '0;
    int             n_chk = 0;
    int             n_err = 0;
    int             n_reads = 0;

    mem_arr_rd_seq #(.SYS_ROW(SR), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len), .stall(stall),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // one drive slot and the outputs expected right after the edge that samples it
    task automatic push(input drv_t d, input logic b, input logic dn, input logic [SR-1:0] en,
                        input logic [SR-1:0][AW-1:0] a);
        exp_t e;
        e.busy = b; e.done = dn; e.en = en; e.dv = last_en; e.addr = a;
        exp_q.push_back(e);
        drv_q.push_back(d);
        last_en = en;
        n_reads += $countones(en);
    endtask

    task automatic idle_slot();
        push('{1'b0, 1'b1, 8'h00, 9'd0}, 1'b0, 1'b0, '0, '0);
    endtask

    // sweep model: ts/sd = stall sd cycles just before issuing t=ts; hold keeps start high (ignored)
    task automatic build(input logic [AW-1:0] b, input logic [AW:0] l, input int ts, input int sd, input bit hold);
        int L = l > 9'd256 ? 256 : int'(l);
        drv_t busy_d = '{hold, 1'b0, ~b, 9'd5};
        logic [SR-1:0] en;
        logic [SR-1:0][AW-1:0] a;
        push('{1'b1, 1'b0, b, l}, 1'b0, 1'b0, '0, '0);
        if (L == 0) return;
        for (int t = 0; t <= L + SR - 2; t++) begin
            if (t == ts)
                for (int s = 0; s < sd; s++) push('{hold, 1'b1, ~b, 9'd5}, 1'b1, 1'b0, '0, '0);
            for (int i = 0; i < SR; i++) begin
                en[i] = (t >= i) && (t < i + L);
                a[i]  = AW'(int'(b) + t - i);
            end
            push(busy_d, 1'b1, 1'b0, en, a);
        end
        push('{hold, 1'b1, ~b, 9'd5}, 1'b1, 1'b1, '0, '0);
    endtask

    task automatic play();
        exp_t e;
        drv_t d;
        bit   have = 0;
        int   seen = 0;
        while (drv_q.size() > 0 || have) begin
            @(negedge clk);
            if (have) begin
                e = exp_q.pop_front();
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("rd_en", 32'(rd_en), 32'(e.en));
                check("data_valid", 32'(data_valid), 32'(e.dv));
                for (int i = 0; i < SR; i++)
                    if (e.en[i]) check("rd_addr", 32'(rd_addr[i*AW +: AW]), 32'(e.addr[i]));
                seen += $countones(rd_en);
            end
            have = drv_q.size() > 0;
            #1;
            if (have) begin
                d = drv_q.pop_front();
                start = d.start; stall = d.stall; base_addr = d.base; len = d.len;
            end else begin
                start = 1'b0; stall = 1'b0;
            end
        end
        check("reads", 32'(seen), 32'(n_reads));
        n_reads = 0;
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_addr", 32'(|rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        build(8'h10, 9'd3, -1, 0, 1'b0); idle_slot(); play();
        build(8'hFE, 9'd4, -1, 0, 1'b0); idle_slot(); play();
        build(8'h33, 9'd0, -1, 0, 1'b0); idle_slot(); idle_slot(); play();
        build(8'h00, 9'd300, -1, 0, 1'b0); idle_slot(); play();
        build(8'h40, 9'd3, 2, 5, 1'b0); idle_slot(); play();
        build(8'h80, 9'd4, -1, 0, 1'b1); build(8'hC0, 9'd2, -1, 0, 1'b0); idle_slot(); play();

        @(negedge clk);
        #1 start = 1'b1; base_addr = 8'h20; len = 9'd5;
        @(negedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("pre_abort_rd_en", 32'(rd_en), 32'h3);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_dv", 32'(data_valid), 32'd0);
        check("abort_addr", 32'(|rd_addr), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        last_en = '0;
        build(8'h20, 9'd5, -1, 0, 1'b0); idle_slot(); play();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
